// File: rtl/fifo_if.sv
// Producer, consumer and memory-port signals of the FIFO controller.
// master is the controller side; slave is the producer/consumer/memory side.
interface fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
);
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_re;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      input  s_valid, s_data, m_ready, mem_rdata,
      output s_ready, m_valid, m_data, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
   );

   modport slave (
      output s_valid, s_data, m_ready, mem_rdata,
      input  s_ready, m_valid, m_data, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller over a dual-port memory with a registered read port.
// A 2-entry show-ahead stage (head + skid) hides the memory read latency.
module fifo_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   fifo_if.master                bus,
   output logic [ADDR_WIDTH+1:0] count,
   output logic                  almost_full,
   output logic                  almost_empty
);
   localparam int                    DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH+1:0] AF_W    = AFULL_THRESH[ADDR_WIDTH+1:0];
   localparam logic [ADDR_WIDTH+1:0] AE_W    = AEMPTY_THRESH[ADDR_WIDTH+1:0];

   logic [ADDR_WIDTH-1:0] wptr, rptr;
   logic [ADDR_WIDTH:0]   mem_words;
   logic                  rd_pending;
   logic [1:0]            out_cnt;
   logic [DATA_WIDTH-1:0] head, skid;

   logic       push, pop;
   logic [2:0] stage_after;
   logic [1:0] cnt_kept;

   assign push = bus.s_valid && bus.s_ready;
   assign pop  = bus.m_valid && bus.m_ready;

   // rstn gating keeps s_ready low while reset is held.
   assign bus.s_ready = rstn && !flush && (mem_words < DEPTH_W);

   // Only fetch when the stage will have room for the word once it returns.
   assign stage_after = {1'b0, out_cnt} + {2'b00, rd_pending} - {2'b00, pop};
   assign bus.mem_re  = (mem_words != '0) && (stage_after < 3'd2) && !flush;

   assign bus.mem_we    = push;
   assign bus.mem_waddr = wptr;
   assign bus.mem_wdata = bus.s_data;
   assign bus.mem_raddr = rptr;
   assign bus.m_valid   = (out_cnt != 2'd0);
   assign bus.m_data    = head;

   assign cnt_kept = out_cnt - {1'b0, pop};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr       <= '0;
         rptr       <= '0;
         mem_words  <= '0;
         rd_pending <= 1'b0;
         out_cnt    <= 2'd0;
         head       <= '0;
         skid       <= '0;
      end else if (flush) begin
         // A read returning next cycle is dropped because rd_pending clears here.
         wptr       <= '0;
         rptr       <= '0;
         mem_words  <= '0;
         rd_pending <= 1'b0;
         out_cnt    <= 2'd0;
      end else begin
         if (push)       wptr <= wptr + 1'b1;
         if (bus.mem_re) rptr <= rptr + 1'b1;
         mem_words  <= mem_words + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, bus.mem_re};
         rd_pending <= bus.mem_re;
         out_cnt    <= cnt_kept + {1'b0, rd_pending};
         if (pop && out_cnt == 2'd2) head <= skid;
         if (rd_pending) begin
            if (cnt_kept == 2'd0) head <= bus.mem_rdata;
            else                  skid <= bus.mem_rdata;
         end
      end
   end

   assign count        = {1'b0, mem_words} + {{(ADDR_WIDTH+1){1'b0}}, rd_pending}
                       + {{ADDR_WIDTH{1'b0}}, out_cnt};
   assign almost_full  = (count >= AF_W);
   assign almost_empty = (count <= AE_W);
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that sequences a dual-port memory: write pointer, read pointer, occupancy, flags, and a 2-entry show-ahead output stage that hides the memory's 1-cycle registered read latency. It sits between a valid/ready producer and consumer and drives the memory's write and read ports. FIFO storage is the memory; this block holds at most two extra words in its output stage.

## Interface
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 10, memory address width; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value.

- clk  in  1  clock, all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all FIFO contents.
- s_valid  in  1  producer word valid.
- s_ready  out  1  controller accepts a word.
- s_data  in  DATA_WIDTH  producer word.
- m_valid  out  1  head word valid.
- m_ready  in  1  consumer takes the head word.
- m_data  out  DATA_WIDTH  head word, registered.
- mem_we  out  1  memory write enable.
- mem_waddr  out  ADDR_WIDTH  memory write address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_re  out  1  memory read enable.
- mem_raddr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_re.
- count  out  ADDR_WIDTH+2  total words held: memory + in-flight read + output stage.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.

## Operation
- State registers:
  - wptr, rptr: ADDR_WIDTH bits, natural wrap from DEPTH-1 to 0.
  - mem_words: ADDR_WIDTH+1 bits, 0..DEPTH.
  - rd_pending: 1 bit.
  - out_cnt: 0..2, output stage of head register plus skid register.
- push = s_valid && s_ready. Its effects are combinational in the same cycle:
  - mem_we = push, mem_waddr = wptr, mem_wdata = s_data.
  - At the edge, wptr increments.
- s_ready = (mem_words < DEPTH) && !flush. It depends only on registered state, with no same-cycle pop bypass.
- mem_re = (mem_words > 0) && ((out_cnt + rd_pending - pop) < 2) && !flush, where pop = m_valid && m_ready.
  - mem_raddr = rptr.
  - At the edge, rptr increments and rd_pending is set.
- When rd_pending is set, mem_rdata is loaded into the head register if the head is free after any pop; otherwise it goes to the skid register. rd_pending then clears unless a new read was issued.
- On pop, the skid word moves to the head.
- FIFO order is strictly preserved. The head always holds the oldest word.
- mem_words update: +push − mem_re. Simultaneous push and read leaves it unchanged.
- Reads are only issued for addresses written on an earlier edge. Same-address read/write in one cycle never occurs.
- flush has priority over push, pop and read at its edge. It zeroes wptr, rptr, mem_words, out_cnt and rd_pending, and discards any read returning on the next cycle.
- Memory contents are never cleared by this block.
- Flags are derived combinationally from the registered counters, with no additional latency.

## Timing
- Reset (rstn low):
  - s_ready=0, m_valid=0, m_data=0, mem_we=0, mem_re=0, count=0, almost_full=0, almost_empty=1.
  - All pointers and counters are 0.
  - s_ready rises in the first cycle after rstn deasserts.
- Fall-through latency:
  - A word pushed at edge E0 into an empty FIFO triggers mem_re in the cycle after E0 (read at edge E1).
  - m_valid=1 with that word on m_data after edge E2.
- Sustained throughput is one push and one pop per cycle once the output stage is primed.
- m_data and m_valid hold stable while m_valid=1 and m_ready=0.
- Capacity:
  - s_ready drops when mem_words reaches DEPTH.
  - With m_ready held low, DEPTH+2 words are accepted in total.
- count and the flags update on the edge after the push or pop.
- rstn assertion mid-transfer clears everything immediately. The in-flight read data is ignored after release.

## Test plan
- Use ADDR_WIDTH=2, AFULL_THRESH=5, AEMPTY_THRESH=1 for all scenarios.
- Fill: push 0x11..0x16 with m_ready=0.
  - Exactly 6 accepted; s_ready=0 after the 6th.
  - count=6, almost_full=1.
  - Then m_ready=1: pops in order 0x11..0x16, m_valid=0 afterward, count=0.
- Latency: single push 0xA5 at edge E0 into an empty FIFO.
  - mem_re high in the cycle after E0.
  - m_valid=1 with m_data=0xA5 after E2.
- Streaming and wrap: continuous push of 0..19 with m_ready=1.
  - All 20 words out in order.
  - rptr/wptr wrap 3→0 five times.
  - No mem_raddr equal to the same-cycle mem_waddr with both enables high.
- Backpressure: 4 words queued; toggle m_ready 1,0,0,1,1.
  - m_data is stable while stalled.
  - No loss or duplication.
- Flush: 4 words held with a read in flight; assert flush for one cycle together with s_valid=1.
  - Push not accepted.
  - Next cycle count=0, m_valid=0, almost_empty=1.
  - A later push 0x3C emerges as the first word.
- Reset mid-operation: rstn low for one cycle with 3 words held.
  - Outputs take their reset values immediately.
  - After release, the FIFO behaves as empty.
